// File: rtl/alu_4bit_pkg.sv
// -----------------------------------------------------------------------------
// alu_4bit_pkg
// Shared constants for the 4-bit registered ALU: data width and the 3-bit
// operation codes carried on the sel field of alu_4bit_if.
// -----------------------------------------------------------------------------
package alu_4bit_pkg;

    localparam int WIDTH = 4;

    // sel[2] = 0 selects the adder-based ops, sel[2] = 1 the bitwise ops.
    localparam logic [2:0] OP_INC = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

endpackage

// File: rtl/alu_4bit_if.sv
// -----------------------------------------------------------------------------
// alu_4bit_if
// Operation bus of the ALU. The master drives one operation per cycle
// (sel, a, b, cin); the slave returns the registered result (f, cout) one
// cycle later. There is no handshake.
//   sel  [2:0]        operation select (OP_* in alu_4bit_pkg)
//   a    [WIDTH-1:0]  operand A, unsigned
//   b    [WIDTH-1:0]  operand B, unsigned
//   cin               carry-in, used by ADD only
//   f    [WIDTH-1:0]  registered result
//   cout              registered carry / no-borrow flag
// -----------------------------------------------------------------------------
interface alu_4bit_if
    import alu_4bit_pkg::*;
#(
    parameter int WIDTH = alu_4bit_pkg::WIDTH
);
    logic [2:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] f;
    logic             cout;

    modport master (output sel, output a, output b, output cin,
                    input  f,   input  cout);

    modport slave  (input  sel, input  a, input  b, input  cin,
                    output f,   output cout);

endinterface

// File: rtl/alu_4bit_adder.sv
// -----------------------------------------------------------------------------
// alu_4bit_adder
// Ripple-carry adder shared by INC/ADD/SUB/DEC. The caller shapes the
// operands and carry-in; this block only adds.
//   a_i    [WIDTH-1:0]  addend A
//   b_i    [WIDTH-1:0]  addend B
//   cin_i               carry into bit 0
//   sum_o  [WIDTH-1:0]  low WIDTH bits of a_i + b_i + cin_i
//   cout_o              carry out of the top bit
// -----------------------------------------------------------------------------
module alu_4bit_adder
    import alu_4bit_pkg::*;
#(
    parameter int WIDTH = alu_4bit_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = cin_i;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign cout_o = carry[WIDTH];

endmodule

// File: rtl/alu_4bit.sv
// -----------------------------------------------------------------------------
// alu_4bit
// 4-bit ALU with a registered result: operands sampled on a rising edge
// produce f/cout right after that edge (1-cycle latency, 1 op per cycle).
// Arithmetic ops run through one shared ripple adder with operand/carry
// muxing; bitwise ops are computed here and merged in the result mux.
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears f and cout
//   bus   alu_4bit_if slave: sel/a/b/cin in, f/cout out
// -----------------------------------------------------------------------------
module alu_4bit
    import alu_4bit_pkg::*;
#(
    parameter int WIDTH = alu_4bit_pkg::WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    alu_4bit_if.slave  bus
);

    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;

    logic [WIDTH-1:0] f_d;
    logic             cout_d;
    logic [WIDTH-1:0] f_q;
    logic             cout_q;

    // Operand shaping for the shared adder:
    //   INC: a + 0    + 1    (carry out only when a wraps from all-ones)
    //   ADD: a + b    + cin
    //   SUB: a + ~b   + 1    (carry out = no borrow, i.e. a >= b)
    //   DEC: a + 1..1 + 0    (carry out = a != 0)
    always_comb begin
        add_b   = '0;
        add_cin = 1'b0;
        unique case (bus.sel)
            OP_INC: begin
                add_b   = '0;
                add_cin = 1'b1;
            end
            OP_ADD: begin
                add_b   = bus.b;
                add_cin = bus.cin;
            end
            OP_SUB: begin
                add_b   = ~bus.b;
                add_cin = 1'b1;
            end
            OP_DEC: begin
                add_b   = '1;
                add_cin = 1'b0;
            end
            default: begin
                add_b   = '0;
                add_cin = 1'b0;
            end
        endcase
    end

    alu_4bit_adder #(
        .WIDTH (WIDTH)
    ) u_adder (
        .a_i    (bus.a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    // Result mux: bitwise ops never report a carry.
    always_comb begin
        f_d    = '0;
        cout_d = 1'b0;
        unique case (bus.sel)
            OP_INC, OP_ADD, OP_SUB, OP_DEC: begin
                f_d    = add_sum;
                cout_d = add_cout;
            end
            OP_AND: f_d = bus.a & bus.b;
            OP_OR:  f_d = bus.a | bus.b;
            OP_XOR: f_d = bus.a ^ bus.b;
            OP_NOT: f_d = ~bus.a;
            default: begin
                f_d    = '0;
                cout_d = 1'b0;
            end
        endcase
    end

    // ---- output register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            f_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            f_q    <= f_d;
            cout_q <= cout_d;
        end
    end

    assign bus.f    = f_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_alu_4bit.sv
// -----------------------------------------------------------------------------
// tb_alu_4bit
// Directed-vector bench for alu_4bit. Inputs change on the falling edge,
// results are sampled 1 time unit after the following rising edge.
// Expected values are {cout, f} written out by hand.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_4bit;
    import alu_4bit_pkg::*;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    alu_4bit_if bus ();

    alu_4bit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: {cout, f} against the expected value.
    task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got cout,f=%b_%b expected %b_%b",
                     tag, got[4], got[3:0], exp[4], exp[3:0]);
        end
    endtask

    task automatic drive(input logic [2:0] s, input logic [3:0] va,
                         input logic [3:0] vb, input logic c);
        @(negedge clk);
        bus.sel = s;
        bus.a   = va;
        bus.b   = vb;
        bus.cin = c;
    endtask

    // Apply one operation and check the result right after the capturing edge.
    task automatic op(input string tag, input logic [2:0] s, input logic [3:0] va,
                      input logic [3:0] vb, input logic c, input logic [4:0] exp);
        drive(s, va, vb, c);
        @(posedge clk);
        #1;
        chk(tag, {bus.cout, bus.f}, exp);
    endtask

    typedef struct {
        string      tag;
        logic [2:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic       cin;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t b2b[$];

    // Watchdog: the bench is cycle-driven, this only guards against a stall.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        bus.sel  = OP_ADD;
        bus.a    = 4'b1010;
        bus.b    = 4'b0101;
        bus.cin  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {bus.cout, bus.f}, 5'b0_0000);
        @(negedge clk);
        rst = 1'b0;

        // ----------------------------------------------------- directed vectors
        vecs.push_back('{"add_5_3",      OP_ADD, 4'b0101, 4'b0011, 1'b0, 5'b0_1000});
        vecs.push_back('{"add_6_4_c1",   OP_ADD, 4'b0110, 4'b0100, 1'b1, 5'b0_1011});
        vecs.push_back('{"add_wrap",     OP_ADD, 4'b1111, 4'b0001, 1'b0, 5'b1_0000});
        vecs.push_back('{"sub_8_3",      OP_SUB, 4'b1000, 4'b0011, 1'b0, 5'b1_0101});
        vecs.push_back('{"sub_borrow",   OP_SUB, 4'b0011, 4'b1000, 1'b0, 5'b0_1011});
        vecs.push_back('{"sub_eq_cin1",  OP_SUB, 4'b0101, 4'b0101, 1'b1, 5'b1_0000});
        vecs.push_back('{"inc_4_cin1",   OP_INC, 4'b0100, 4'b1001, 1'b1, 5'b0_0101});
        vecs.push_back('{"inc_wrap",     OP_INC, 4'b1111, 4'b0000, 1'b0, 5'b1_0000});
        vecs.push_back('{"dec_6",        OP_DEC, 4'b0110, 4'b0011, 1'b1, 5'b1_0101});
        vecs.push_back('{"dec_zero",     OP_DEC, 4'b0000, 4'b0000, 1'b0, 5'b0_1111});
        vecs.push_back('{"and",          OP_AND, 4'b1101, 4'b1010, 1'b1, 5'b0_1000});
        vecs.push_back('{"or",           OP_OR,  4'b1101, 4'b1010, 1'b1, 5'b0_1111});
        vecs.push_back('{"xor",          OP_XOR, 4'b1100, 4'b1010, 1'b1, 5'b0_0110});
        vecs.push_back('{"not",          OP_NOT, 4'b1100, 4'b1010, 1'b1, 5'b0_0011});
        vecs.push_back('{"not_b_ignored",OP_NOT, 4'b1100, 4'b0101, 1'b0, 5'b0_0011});

        foreach (vecs[i])
            op(vecs[i].tag, vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp);

        // Output holds while inputs change between edges (no comb path).
        op("hold_setup", OP_ADD, 4'b0001, 4'b0010, 1'b0, 5'b0_0011);
        drive(OP_NOT, 4'b0000, 4'b0000, 1'b0);
        #1;
        chk("hold_mid_cycle", {bus.cout, bus.f}, 5'b0_0011);
        @(posedge clk);
        #1;
        chk("hold_next_edge", {bus.cout, bus.f}, 5'b0_1111);

        // Reset priority over a pending ADD 1111+1111, then recovery.
        drive(OP_ADD, 4'b1111, 4'b1111, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_priority", {bus.cout, bus.f}, 5'b0_0000);
        @(negedge clk);
        #1;
        chk("rst_no_async", {bus.cout, bus.f}, 5'b0_0000);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_recover", {bus.cout, bus.f}, 5'b1_1110);

        // Back-to-back: a new op every cycle, a=1010 b=0110 cin=1.
        b2b.push_back('{"b2b_inc", OP_INC, 4'b1010, 4'b0110, 1'b1, 5'b0_1011});
        b2b.push_back('{"b2b_add", OP_ADD, 4'b1010, 4'b0110, 1'b1, 5'b1_0001});
        b2b.push_back('{"b2b_sub", OP_SUB, 4'b1010, 4'b0110, 1'b1, 5'b1_0100});
        b2b.push_back('{"b2b_dec", OP_DEC, 4'b1010, 4'b0110, 1'b1, 5'b1_1001});
        b2b.push_back('{"b2b_and", OP_AND, 4'b1010, 4'b0110, 1'b1, 5'b0_0010});
        b2b.push_back('{"b2b_or",  OP_OR,  4'b1010, 4'b0110, 1'b1, 5'b0_1110});
        b2b.push_back('{"b2b_xor", OP_XOR, 4'b1010, 4'b0110, 1'b1, 5'b0_1100});
        b2b.push_back('{"b2b_not", OP_NOT, 4'b1010, 4'b0110, 1'b1, 5'b0_0101});

        foreach (b2b[i])
            op(b2b[i].tag, b2b[i].sel, b2b[i].a, b2b[i].b, b2b[i].cin, b2b[i].exp);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
